// File: rtl/add64_seq_112_pkg.sv
// Shared definitions for the sequenced wide adder: FSM encoding, slice width
// and the operand-width legality rule.
package add64_seq_112_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic width_legal(input int unsigned w);
    return (w >= SLICE_W) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/add64_seq_112_cla16.sv
// Shared 16-bit carry-lookahead slice. The block carry-out is left to the caller,
// which forms it from the group generate/propagate terms.
module cla16_112 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        gx_o,
  output logic        px_o
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  pg;
  logic [3:0]  gg;
  logic [3:0]  gc;

  always_comb begin
    p = a_i ^ b_i;
    g = a_i & b_i;
    for (int j = 0; j < 4; j++) begin
      pg[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Second-level lookahead gives each 4-bit group its carry-in directly.
    gc[0] = c_i;
    gc[1] = gg[0] | (pg[0] & c_i);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_i);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c_i);
    for (int j = 0; j < 4; j++) begin
      c[4*j] = gc[j];
      for (int m = 1; m < 4; m++) begin
        c[4*j+m] = g[4*j+m-1] | (p[4*j+m-1] & c[4*j+m-1]);
      end
    end
    s_o  = p ^ c;
    gx_o = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
    px_o = &pg;
  end

endmodule

// File: rtl/add64_seq_112.sv
// Wide add/subtract built by stepping one shared 16-bit CLA across the operand,
// one slice per cycle, with the inter-slice carry held in a register.
module add64_seq_112
  import add64_seq_112_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N      = WIDTH / SLICE_W;
  localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("add64_seq_112: WIDTH must be a multiple of 16 and at least 16");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic             accept;
  logic             last_slice;
  logic [KW+3:0]    slice_off;
  logic [15:0]      slice_a, slice_b, slice_s;
  logic             slice_gx, slice_px, slice_co;

  assign accept     = start & ready;
  assign last_slice = (k_q == K_LAST);
  assign slice_off  = {k_q, 4'd0};
  assign slice_a    = a_q[slice_off +: SLICE_W];
  assign slice_b    = b_q[slice_off +: SLICE_W];
  assign slice_co   = slice_gx | (slice_px & carry_q);

  cla16_112 u_cla (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .c_i  (carry_q),
    .s_o  (slice_s),
    .gx_o (slice_gx),
    .px_o (slice_px)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = last_slice ? ST_DONE : ST_RUN;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_RUN:  busy  = 1'b1;
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Subtraction is folded in at accept: store ~b and force the carry-in to 1.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      k_d     = '0;
    end else if (state_q == ST_RUN) begin
      sum_d[slice_off +: SLICE_W] = slice_s;
      carry_d = slice_co;
      if (last_slice) begin
        cout_d = slice_co;
        ovf_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[SLICE_W-1] ^ slice_co;
      end else begin
        k_d = k_q + KW'(1);
      end
    end else begin
      k_d = k_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_add64_seq_112.sv
// Self-checking bench for add64_seq_112 against a plain-arithmetic reference model.
module tb_add64_seq_112;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         c;
  } op_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  add64_seq_112 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Reference: subtraction as true a-b with unsigned compare for no-borrow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       input logic mc, output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    if (ms) begin
      s  = ma - mb;
      co = (ma >= mb);
      ov = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      s  = full[W-1:0];
      co = full[W];
      ov = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input logic tc, output int lat);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf got=%b%b exp=00", cout, ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_corners();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vs [5];
    logic         vc [5];
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat;
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd0; vs[0] = 1'b0; vc[0] = 1'b1;
    va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'd1; vs[1] = 1'b0; vc[1] = 1'b0;
    va[2] = 64'd5;                   vb[2] = 64'd7; vs[2] = 1'b1; vc[2] = 1'b0;
    va[3] = 64'd7;                   vb[3] = 64'd5; vs[3] = 1'b1; vc[3] = 1'b1;
    va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1; vs[4] = 1'b1; vc[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model(va[i], vb[i], vs[i], vc[i], es, ec, eo);
      issue(va[i], vb[i], vs[i], vc[i], lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL corner%0d_latency got=%0d exp=4", i, lat); end
      checks++; if (sum !== es) begin errors++; $display("FAIL corner%0d_sum got=%h exp=%h", i, sum, es); end
      checks++; if (cout !== ec) begin errors++; $display("FAIL corner%0d_cout got=%b exp=%b", i, cout, ec); end
      checks++; if (ovf !== eo) begin errors++; $display("FAIL corner%0d_ovf got=%b exp=%b", i, ovf, eo); end
      tick();
      checks++; if ({done, ready} !== 2'b01) begin errors++; $display("FAIL corner%0d_done_pulse got=%b%b exp=01", i, done, ready); end
      checks++; if (sum !== es) begin errors++; $display("FAIL corner%0d_sum_hold got=%h exp=%h", i, sum, es); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a1, b1, es, cap_s;
    logic         ec, eo, cap_c, cap_o;
    int           ndone, first;
    a1 = rnd64(); b1 = rnd64();
    model(a1, b1, 1'b0, 1'b1, es, ec, eo);
    a = a1; b = b1; sub = 1'b0; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; a = rnd64(); b = rnd64(); sub = 1'b1;
    tick(); tick();
    start = 1'b1; a = rnd64(); b = rnd64(); cin = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    tick();
    start = 1'b0;
    ndone = 0; first = -1; cap_s = '0; cap_c = 1'b0; cap_o = 1'b0;
    for (int i = 4; i <= 14; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = i; cap_s = sum; cap_c = cout; cap_o = ovf;
        end
      end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (first !== 4) begin errors++; $display("FAIL ignore_done_cycle got=%0d exp=4", first); end
    checks++; if ({cap_s, cap_c, cap_o} !== {es, ec, eo}) begin
      errors++; $display("FAIL ignore_result got=%h/%b/%b exp=%h/%b/%b", cap_s, cap_c, cap_o, es, ec, eo);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] es, a2, b2;
    logic         ec, eo;
    int           seen, lat;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd0; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (sum === '0) begin errors++; $display("FAIL midrst_partial got=%h exp=nonzero", sum); end
    rst = 1'b1;
    #1;
    checks++; if (sum !== '0) begin errors++; $display("FAIL midrst_sum got=%h exp=0", sum); end
    checks++; if ({busy, ready, done} !== 3'b010) begin errors++; $display("FAIL midrst_flags got=%b exp=010", {busy, ready, done}); end
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    a2 = rnd64(); b2 = rnd64();
    model(a2, b2, 1'b1, 1'b0, es, ec, eo);
    issue(a2, b2, 1'b1, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
    checks++; if ({sum, cout, ovf} !== {es, ec, eo}) begin
      errors++; $display("FAIL midrst_next_result got=%h/%b/%b exp=%h/%b/%b", sum, cout, ovf, es, ec, eo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    op_t          q[$];
    op_t          pend, got;
    logic [W-1:0] es;
    logic         ec, eo;
    tick(); tick();
    pend.a = rnd64(); pend.b = rnd64(); pend.s = 1'($urandom_range(0, 1)); pend.c = 1'($urandom_range(0, 1));
    a = pend.a; b = pend.b; sub = pend.s; cin = pend.c; start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if ((c % 5) == 0) q.push_back(pend);
      #1;
      checks++; if (done !== ((c % 5) == 4)) begin errors++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, ((c % 5) == 4)); end
      checks++; if (busy !== ((c % 5) != 4)) begin errors++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, ((c % 5) != 4)); end
      if ((c % 5) == 4) begin
        got = q.pop_front();
        model(got.a, got.b, got.s, got.c, es, ec, eo);
        checks++; if ({sum, cout, ovf} !== {es, ec, eo}) begin
          errors++; $display("FAIL b2b_result c=%0d got=%h/%b/%b exp=%h/%b/%b", c, sum, cout, ovf, es, ec, eo);
        end
      end
      pend.a = rnd64(); pend.b = rnd64(); pend.s = 1'($urandom_range(0, 1)); pend.c = 1'($urandom_range(0, 1));
      a = pend.a; b = pend.b; sub = pend.s; cin = pend.c;
    end
    start = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_corners();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add64_seq_112.md
# add64_seq_112

Sequenced 64-bit adder/subtractor controller. It time-multiplexes a single 16-bit carry-lookahead slice over WIDTH/16 cycles, chaining the inter-slice carry through a register. It accepts one operation per start/ready handshake and pulses done when the full-width result is valid. It sits between the ALU issue logic and the shared 16-bit CLA, giving wide arithmetic without replicating adder hardware.

## Interface
- WIDTH, 64, operand width; must be a multiple of 16, minimum 16
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted on a rising edge when ready=1
- sub  in  1  0: a+b+cin; 1: a+~b+1 (cin ignored)
- cin  in  1  carry-in for add
- a  in  WIDTH  operand A, sampled at accept
- b  in  WIDTH  operand B, sampled at accept
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse: result valid
- sum  out  WIDTH  result, held until next accept
- cout  out  1  carry out of MSB
- ovf  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE. Slice counter k, 0..N-1, N=WIDTH/16.
- IDLE/DONE, start=1: latch a; latch b (or ~b if sub); latch carry register (cin, or 1 if sub). Clear k. Go to RUN.
- IDLE, start=0: stay. DONE, start=0: go to IDLE.
- RUN: drive the slice with a[16k+15:16k], b'[16k+15:16k] and the carry register.
  - Write the slice sum into sum[16k+15:16k].
  - Carry register <= gx | (px & carry).
  - k<N-1: k+1. k=N-1: go to DONE; cout <= slice carry-out; ovf <= a[MSB] ^ b'[MSB] ^ sum[MSB] ^ cout.
- start while busy=1 is ignored; no queuing. Operands are sampled only at accept, so later input changes have no effect.
- Result arithmetic is modulo 2^WIDTH. sub borrow convention: cout=1 means no borrow.
- Reset values: state=IDLE, k=0, sum=0, cout=0, ovf=0, done=0, busy=0, ready=1, carry register=0.
- Reset mid-operation aborts the operation. All outputs return to reset values immediately (asynchronously). done does not pulse.

## Timing
- Accept at edge E0. Slice k is written at edge E(k+1). done=1 in the cycle after edge EN, which is N=4 cycles after accept for WIDTH=64.
- sum, cout and ovf are all valid while done=1 and stay stable until the next accept edge.
- Back-to-back: start=1 during DONE is accepted at that edge. Throughput is one result per N+1 cycles.
- Partial sum bits are visible during RUN. Consumers sample only when done=1.
- The slice path is combinational within one cycle: mux, CLA, carry update. No multicycle paths.

## Structure
- Shared package: state encoding constants (IDLE/RUN/DONE), SLICE_W=16, and the WIDTH legality check.
- One sub-module: a single instance of the existing 16-bit CLA, cla16_112. Its carry-out is formed here as gx | (px & carry).
- FSM, slice counter, operand registers, carry register and result registers live in add64_seq_112.

## Test plan
- a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, ovf=0. Carry ripples through all four slices.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
- start pulsed again 2 cycles after accept with different operands -> ignored. done pulses exactly once, 4 cycles after the first accept, with the first result.
- rst asserted while k=2 -> sum=0, busy=0, ready=1 immediately. No done pulse. The next op completes correctly.
- start held high continuously with random operands -> done every 5 cycles. Each result matches the golden model for operands sampled at its accept edge.
